// File: rtl/isp_pkg.sv
// Shared types and defaults for the image SRAM responder.
// Holds pixel/coordinate widths, the border pixel value and the responder state encoding.
package isp_pkg;

  localparam int PIX_W   = 8;
  localparam int COORD_W = 9;

  typedef logic [PIX_W-1:0]   pixel_t;
  typedef logic [COORD_W-1:0] coord_t;

  localparam pixel_t BORDER_VAL = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } resp_state_t;

endpackage

// File: rtl/sram_bank.sv
// Single-port synchronous frame memory with a registered read port.
// A cycle is either a write or a read; rdata only changes on an enabled read.
module sram_bank #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/image_sram_responder.sv
// Frame-store responder: loads one raster frame, then serves (x, y) pixel reads at a
// fixed latency, returning a border value for coordinates outside the image.
module image_sram_responder
  import isp_pkg::*;
#(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int PIX_W      = isp_pkg::PIX_W,
  parameter int ADDR_W     = isp_pkg::COORD_W,
  parameter int RD_LATENCY = 2,
  parameter logic [PIX_W-1:0] BORDER_VAL = PIX_W'(isp_pkg::BORDER_VAL)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              new_frame,
  input  logic              wr_valid,
  input  logic [PIX_W-1:0]  wr_pixel,
  output logic              wr_ready,
  output logic              frame_loaded,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [ADDR_W-1:0] y_addr,
  output logic [PIX_W-1:0]  rd_pixel,
  output logic              rd_valid,
  output logic              rd_oob,
  output logic              rd_err
);

  localparam int DEPTH  = IMG_W * IMG_H;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam int WX_W   = $clog2(IMG_W);
  localparam int WY_W   = $clog2(IMG_H);

  localparam logic [WX_W-1:0]   WX_LAST = WX_W'(IMG_W - 1);
  localparam logic [WY_W-1:0]   WY_LAST = WY_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] X_LIM   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] Y_LIM   = ADDR_W'(IMG_H);

  resp_state_t state, state_next;

  logic [WX_W-1:0]   wx;
  logic [WY_W-1:0]   wy;
  logic              wr_fire;
  logic              wr_last;
  logic              rd_fire;
  logic              rd_in_range;
  logic [MEM_AW-1:0] wr_addr;
  logic [MEM_AW-1:0] rd_addr;
  logic [MEM_AW-1:0] ram_addr;
  logic              ram_en;
  logic [PIX_W-1:0]  ram_rdata;

  logic              s1_valid;
  logic              s1_oob;
  logic [PIX_W-1:0]  s1_data;
  logic              fin_valid;
  logic              fin_oob;
  logic [PIX_W-1:0]  fin_data;
  logic [PIX_W-1:0]  hold_pixel;
  logic              err_q;

  // new_frame always wins over a write or read presented in the same cycle.
  assign wr_fire     = (state == LOAD) && wr_valid && !new_frame;
  assign wr_last     = wr_fire && (wx == WX_LAST) && (wy == WY_LAST);
  assign rd_fire     = (state == READY) && rd_en && !new_frame;
  assign rd_in_range = (x_addr < X_LIM) && (y_addr < Y_LIM);

  assign wr_addr = MEM_AW'(wy) * MEM_AW'(IMG_W) + MEM_AW'(wx);
  assign rd_addr = rd_in_range ? (MEM_AW'(y_addr) * MEM_AW'(IMG_W) + MEM_AW'(x_addr)) : '0;

  assign ram_addr = (state == LOAD) ? wr_addr : rd_addr;
  assign ram_en   = wr_fire || (rd_fire && rd_in_range);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (new_frame) state_next = LOAD;
      end
      LOAD: begin
        if (new_frame)    state_next = LOAD;
        else if (wr_last) state_next = READY;
      end
      READY: begin
        if (new_frame) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wx <= '0;
      wy <= '0;
    end else if (new_frame) begin
      wx <= '0;
      wy <= '0;
    end else if (wr_fire) begin
      if (wx == WX_LAST) begin
        wx <= '0;
        wy <= (wy == WY_LAST) ? '0 : wy + 1'b1;
      end else begin
        wx <= wx + 1'b1;
      end
    end
  end

  sram_bank #(
    .DEPTH (DEPTH),
    .AW    (MEM_AW),
    .DW    (PIX_W)
  ) u_bank (
    .clk   (clk),
    .en    (ram_en),
    .we    (wr_fire),
    .addr  (ram_addr),
    .wdata (wr_pixel),
    .rdata (ram_rdata)
  );

  // First read stage lines up with the RAM's registered output.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      s1_oob   <= !rd_in_range;
      err_q    <= rd_en && !rd_fire;
    end
  end

  assign s1_data = s1_oob ? BORDER_VAL : ram_rdata;

  generate
    if (RD_LATENCY == 1) begin : g_no_delay
      assign fin_valid = s1_valid;
      assign fin_oob   = s1_oob;
      assign fin_data  = s1_data;
    end else begin : g_delay
      logic [RD_LATENCY-2:0] dly_valid;
      logic [RD_LATENCY-2:0] dly_oob;
      logic [PIX_W-1:0]      dly_data [RD_LATENCY-1];

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          dly_valid <= '0;
          dly_oob   <= '0;
          for (int i = 0; i < RD_LATENCY - 1; i++) dly_data[i] <= '0;
        end else begin
          dly_valid[0] <= s1_valid;
          dly_oob[0]   <= s1_oob;
          dly_data[0]  <= s1_data;
          for (int i = 1; i < RD_LATENCY - 1; i++) begin
            dly_valid[i] <= dly_valid[i-1];
            dly_oob[i]   <= dly_oob[i-1];
            dly_data[i]  <= dly_data[i-1];
          end
        end
      end

      assign fin_valid = dly_valid[RD_LATENCY-2];
      assign fin_oob   = dly_oob[RD_LATENCY-2];
      assign fin_data  = dly_data[RD_LATENCY-2];
    end
  endgenerate

  // rd_pixel keeps the last delivered pixel between responses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_pixel <= '0;
    end else begin
      hold_pixel <= rd_pixel;
    end
  end

  assign rd_pixel     = fin_valid ? fin_data : hold_pixel;
  assign rd_valid     = fin_valid;
  assign rd_oob       = fin_valid && fin_oob;
  assign rd_err       = err_q;
  assign wr_ready     = (state == LOAD);
  assign frame_loaded = (state == READY);

endmodule

// File: tb/tb_image_sram_responder.sv
// Self-checking bench for image_sram_responder on an 8x8 image with read latency 2.
// Read responses are matched against a queue of expected pixels and due cycles.
module tb_image_sram_responder;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 9;
  localparam int LAT    = 2;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              new_frame = 1'b0;
  logic              wr_valid = 1'b0;
  logic [PIX_W-1:0]  wr_pixel = '0;
  logic              wr_ready;
  logic              frame_loaded;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] x_addr = '0;
  logic [ADDR_W-1:0] y_addr = '0;
  logic [PIX_W-1:0]  rd_pixel;
  logic              rd_valid;
  logic              rd_oob;
  logic              rd_err;

  image_sram_responder #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .PIX_W      (PIX_W),
    .ADDR_W     (ADDR_W),
    .RD_LATENCY (LAT),
    .BORDER_VAL (8'h00)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .new_frame    (new_frame),
    .wr_valid     (wr_valid),
    .wr_pixel     (wr_pixel),
    .wr_ready     (wr_ready),
    .frame_loaded (frame_loaded),
    .rd_en        (rd_en),
    .x_addr       (x_addr),
    .y_addr       (y_addr),
    .rd_pixel     (rd_pixel),
    .rd_valid     (rd_valid),
    .rd_oob       (rd_oob),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] pix;
    logic       oob;
  } rd_exp_t;

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    logic [7:0] pix;
    logic       oob;
  } vec_t;

  rd_exp_t rd_q[$];
  int      err_q[$];
  vec_t    vecs[10];
  int      cycle = 0;
  int      checks = 0;
  int      errors = 0;
  int      m_state = M_IDLE;
  int      m_count = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cycle);
    end
  endtask

  // Drive one cycle of inputs, record what the bench expects, then advance to the next cycle.
  task automatic applyStimulus(input logic nf, input logic wv, input logic [7:0] wp,
                               input logic re, input logic [8:0] x, input logic [8:0] y,
                               input logic [7:0] ep, input logic eo);
    rd_exp_t e;
    new_frame = nf;
    wr_valid  = wv;
    wr_pixel  = wp;
    rd_en     = re;
    x_addr    = x;
    y_addr    = y;
    if (re) begin
      if (m_state == M_READY && !nf) begin
        e.due = cycle + LAT;
        e.pix = ep;
        e.oob = eo;
        rd_q.push_back(e);
      end else begin
        err_q.push_back(cycle + 1);
      end
    end
    if (nf) begin
      m_state = M_LOAD;
      m_count = 0;
    end else if (m_state == M_LOAD && wv) begin
      m_count++;
      if (m_count == IMG_W * IMG_H) m_state = M_READY;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 9'd0, 9'd0, 8'h00, 1'b0);
  endtask

  task automatic checkReset();
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_frame_loaded", 32'(frame_loaded), 32'd0);
    checkOutput("rst_rd_pixel", 32'(rd_pixel), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_oob", 32'(rd_oob), 32'd0);
    checkOutput("rst_rd_err", 32'(rd_err), 32'd0);
  endtask

  // Stream npix raster pixels with three idle gaps and one rejected read at pixel 30.
  task automatic loadFrame(input int pat, input int npix);
    logic [7:0] pix;
    for (int i = 0; i < npix; i++) begin
      if (i == 5 || i == 17 || i == 40) idleCycle();
      checkOutput("wr_ready_load", 32'(wr_ready), 32'(m_state == M_LOAD));
      checkOutput("frame_loaded_load", 32'(frame_loaded), 32'(m_state == M_READY));
      pix = (pat == 0) ? 8'(i) : 8'(255 - i);
      applyStimulus(1'b0, 1'b1, pix, (i == 30), 9'd1, 9'd1, 8'h00, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    rd_exp_t e;
    logic exp_err;
    if (n_rst) begin
      while (rd_q.size() > 0 && rd_q[0].due < cycle) begin
        checkOutput("rd_valid_missing", 32'd0, 32'd1);
        void'(rd_q.pop_front());
      end
      if (rd_valid) begin
        if (rd_q.size() == 0 || rd_q[0].due != cycle) begin
          checkOutput("rd_valid_unexpected", 32'd1, 32'd0);
        end else begin
          e = rd_q.pop_front();
          checkOutput("rd_pixel", 32'(rd_pixel), 32'(e.pix));
          checkOutput("rd_oob", 32'(rd_oob), 32'(e.oob));
        end
      end
      exp_err = (err_q.size() > 0 && err_q[0] == cycle);
      if (exp_err) void'(err_q.pop_front());
      checkOutput("rd_err", 32'(rd_err), 32'(exp_err));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{9'd3,   9'd2,   8'h13, 1'b0};
    vecs[1] = '{9'd7,   9'd7,   8'h3F, 1'b0};
    vecs[2] = '{9'd0,   9'd0,   8'h00, 1'b0};
    vecs[3] = '{9'd5,   9'd1,   8'h0D, 1'b0};
    vecs[4] = '{9'd8,   9'd0,   8'h00, 1'b1};
    vecs[5] = '{9'd0,   9'd9,   8'h00, 1'b1};
    vecs[6] = '{9'h1FF, 9'h1FF, 8'h00, 1'b1};
    vecs[7] = '{9'd6,   9'd4,   8'h26, 1'b0};
    vecs[8] = '{9'd7,   9'd8,   8'h00, 1'b1};
    vecs[9] = '{9'd1,   9'd6,   8'h31, 1'b0};

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    checkReset();
    n_rst = 1'b1;
    idleCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 9'd2, 9'd2, 8'h00, 1'b0);
    idleCycle();

    $display("[TB] first frame load");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 9'd0, 9'd0, 8'h00, 1'b0);
    loadFrame(0, IMG_W * IMG_H);
    checkOutput("frame_loaded_after_load", 32'(frame_loaded), 32'd1);
    checkOutput("wr_ready_after_load", 32'(wr_ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0, 9'd0, 9'd0, 8'h00, 1'b0);
    checkOutput("frame_loaded_ignores_wr", 32'(frame_loaded), 32'd1);

    $display("[TB] back-to-back table reads");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, vecs[i].x, vecs[i].y, vecs[i].pix, vecs[i].oob);
    end
    repeat (LAT + 2) idleCycle();

    $display("[TB] new_frame racing an in-flight read");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 9'd2, 9'd0, 8'h02, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 9'd5, 9'd5, 8'h00, 1'b0);
    checkOutput("frame_loaded_after_nf", 32'(frame_loaded), 32'd0);
    checkOutput("wr_ready_after_nf", 32'(wr_ready), 32'd1);
    loadFrame(1, IMG_W * IMG_H);
    checkOutput("frame_loaded_second", 32'(frame_loaded), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 9'd3, 9'd2, 8'hEC, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 9'd0, 9'd0, 8'hFF, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 9'd7, 9'd7, 8'hC0, 1'b0);
    repeat (LAT + 2) idleCycle();

    $display("[TB] reset in the middle of a load");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 9'd0, 9'd0, 8'h00, 1'b0);
    loadFrame(0, 20);
    new_frame = 1'b0;
    wr_valid  = 1'b0;
    rd_en     = 1'b0;
    n_rst     = 1'b0;
    #1;
    checkReset();
    rd_q.delete();
    err_q.delete();
    m_state = M_IDLE;
    m_count = 0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    idleCycle();
    checkOutput("wr_ready_idle_after_rst", 32'(wr_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 9'd0, 9'd0, 8'h00, 1'b0);
    loadFrame(0, IMG_W * IMG_H);
    checkOutput("frame_loaded_after_reload", 32'(frame_loaded), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 9'd7, 9'd7, 8'h3F, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 9'd4, 9'd3, 8'h1C, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 9'd0, 9'd8, 8'h00, 1'b1);
    repeat (LAT + 2) idleCycle();
    checkOutput("rd_pixel_hold", 32'(rd_pixel), 32'h00);

    checkOutput("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    checkOutput("err_queue_drained", 32'(err_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_sram_responder.md
Name: image_sram_responder

Overview:
Frame-store responder serving the read side of the buffer-loader SRAM interface. It sits between the upstream raster pixel stream and the pipelined buffer loader. It is loaded with one frame in raster order, then answers (x_addr, y_addr, read strobe) requests with the pixel at a fixed latency. Out-of-image coordinates return a border value so the loader can sample windows at image edges.

Parameters:
IMG_W, 64, image width in pixels
IMG_H, 64, image height in pixels
PIX_W, 8, pixel width in bits
ADDR_W, 9, coordinate width, unsigned, matching the loader's x_addr/y_addr
RD_LATENCY, 2, cycles from accepted read to rd_valid, legal range 1..4
BORDER_VAL, 0, pixel returned for out-of-range reads

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
new_frame  in  1  single-cycle pulse; discards the current frame and starts a load
wr_valid  in  1  raster pixel valid
wr_pixel  in  PIX_W  raster pixel data
wr_ready  out  1  high while LOAD can accept a pixel
frame_loaded  out  1  high in READY
rd_en  in  1  read strobe, connects to the loader's read_SRAM2
x_addr  in  ADDR_W  read column
y_addr  in  ADDR_W  read row
rd_pixel  out  PIX_W  read data, connects to the loader's input_pixel
rd_valid  out  1  rd_pixel valid this cycle
rd_oob  out  1  with rd_valid: the returned pixel is BORDER_VAL from an out-of-range address
rd_err  out  1  one-cycle pulse: rd_en rejected because the block is not in READY

Behaviour:
- Reset (async, n_rst=0): state IDLE, wx=wy=0, all read pipeline stages invalid.
  - Outputs: wr_ready=0, frame_loaded=0, rd_pixel=0, rd_valid=0, rd_oob=0, rd_err=0.
  - Memory contents are not cleared.
- FSM states: IDLE, LOAD, READY.
  - IDLE -> LOAD on new_frame.
  - LOAD -> READY on acceptance of the last pixel (wx=IMG_W-1, wy=IMG_H-1).
  - READY -> LOAD on new_frame.
  - new_frame in LOAD restarts the load: counters return to 0.
- LOAD:
  - wr_ready=1 combinationally in LOAD.
  - A write is accepted when wr_valid & wr_ready; it writes mem[wy*IMG_W+wx] and advances wx.
  - At wx=IMG_W-1, wx wraps to 0 and wy increments.
  - Gaps in wr_valid are allowed.
  - frame_loaded rises the cycle after the last accepted pixel.
- READY:
  - wr_ready=0; wr_valid is ignored.
  - Each cycle with rd_en=1 is accepted. Back-to-back reads are allowed, throughput 1 per cycle.
- Read pipeline:
  - An accepted read at cycle N gives rd_valid=1 with its data at cycle N+RD_LATENCY, in request order.
  - rd_pixel holds its last value when rd_valid=0.
- Out-of-range reads:
  - Condition: x_addr>=IMG_W or y_addr>=IMG_H. This covers negative loader coordinates wrapped to large unsigned values.
  - Response: rd_pixel=BORDER_VAL and rd_oob=1, same latency, no memory access.
- Address arithmetic: y_addr*IMG_W+x_addr, computed only for in-range reads, width clog2(IMG_W*IMG_H).
- rd_en outside READY: not accepted; rd_err=1 in the next cycle; no rd_valid is produced.
- new_frame and rd_en in the same cycle: new_frame wins; the read is rejected with rd_err.
- Reads already in flight when new_frame arrives still complete with old-frame data.
- The first write of the new load may happen in the cycle after new_frame.
- Reset mid-operation drops all in-flight reads immediately.

Decomposition:
- Shared package isp_pkg holds:
  - PIX_W, COORD_W (9), BORDER_VAL
  - typedef pixel_t, coord_t
  - responder state enum {IDLE, LOAD, READY}
- One sub-module, sram_bank:
  - single-port synchronous RAM, depth IMG_W*IMG_H, write enable, 1-cycle registered read
  - remaining RD_LATENCY-1 stages are a valid/oob/data shift register in the parent
- LOAD and READY are mutually exclusive, so a single port suffices.

Test Plan:
All scenarios use IMG_W=IMG_H=8, RD_LATENCY=2.
1. Reset, then new_frame, then stream 64 pixels of value x+8y with 3 idle gaps -> frame_loaded=1 exactly one cycle after the 64th accept; wr_ready=0 afterwards.
2. Reads at (3,2), (7,7), (0,0) in consecutive cycles -> rd_valid on cycles N+2, N+3, N+4 with rd_pixel 0x13, 0x3F, 0x00; rd_oob=0 each time.
3. Reads at (8,0), (0,9), (0x1FF,0x1FF) -> rd_pixel=0, rd_oob=1, rd_valid at latency 2, no error.
4. rd_en during LOAD at (1,1) -> rd_err=1 for one cycle, no rd_valid; the load count is unaffected.
5. In READY: read (2,0) at N, new_frame with rd_en at N+1 -> rd_valid with 0x02 at N+2, rd_err at N+2, frame_loaded=0 and wr_ready=1 from N+2.
6. n_rst=0 mid-load after 20 pixels, release, new_frame -> all outputs at reset values; the load restarts at wx=wy=0 and needs 64 accepts for frame_loaded.
